// File: rtl/mem_responder_if.sv
// mem_responder_if: controller memory port plus host-side FIFO handshakes.
// The slave modport is the responder's view; master is the controller/host view.
interface mem_responder_if;
    logic [31:0] mem_addr_i;
    logic [7:0]  mem_data_i;
    logic        mem_wr_i;
    logic [7:0]  mem_data_o;
    logic [7:0]  io_tx_data_o;
    logic        io_tx_valid_o;
    logic        io_tx_ready_i;
    logic [7:0]  io_rx_data_i;
    logic        io_rx_valid_i;
    logic        io_rx_ready_o;

    modport slave (
        input  mem_addr_i,
        input  mem_data_i,
        input  mem_wr_i,
        output mem_data_o,
        output io_tx_data_o,
        output io_tx_valid_o,
        input  io_tx_ready_i,
        input  io_rx_data_i,
        input  io_rx_valid_i,
        output io_rx_ready_o
    );

    modport master (
        output mem_addr_i,
        output mem_data_i,
        output mem_wr_i,
        input  mem_data_o,
        input  io_tx_data_o,
        input  io_tx_valid_o,
        output io_tx_ready_i,
        output io_rx_data_i,
        output io_rx_valid_i,
        input  io_rx_ready_o
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: byte RAM with registered one-cycle read toward the controller.
// Define MEM_RESP_IO_EN to add the host I/O window (TX/RX FIFOs, overflow flag).
module mem_responder #(
    parameter int ADDR_BITS  = 17,
    parameter int FIFO_DEPTH = 4
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]           ram [0:(1 << ADDR_BITS) - 1];
    logic [ADDR_BITS-1:0] ram_addr;
    logic                 io_hit;
    logic [7:0]           io_rd;
    logic [7:0]           rd_data;
    logic [7:0]           data_q;
    logic                 unused;

    assign ram_addr       = bus.mem_addr_i[ADDR_BITS-1:0];
    assign rd_data        = io_hit ? io_rd : ram[ram_addr];
    assign bus.mem_data_o = data_q;

    // RAM contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (bus.mem_wr_i && !io_hit) begin
            ram[ram_addr] <= bus.mem_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= 8'h00;
        end else if (!bus.mem_wr_i) begin
            data_q <= rd_data;
        end
    end

`ifdef MEM_RESP_IO_EN
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [15:0]   io_off;
    logic          tx_push;
    logic          tx_acc;
    logic          tx_pop;
    logic          tx_full;
    logic          rx_push;
    logic          rx_pop;
    logic          rx_ne;
    logic          rx_full;
    logic          ovf;
    logic          ovf_clr;
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [PW-1:0] tx_wp;
    logic [PW-1:0] tx_rp;
    logic [PW-1:0] rx_wp;
    logic [PW-1:0] rx_rp;
    logic [CW-1:0] tx_cnt;
    logic [CW-1:0] rx_cnt;

    assign io_hit  = bus.mem_addr_i[17:16] == 2'b11;
    assign io_off  = bus.mem_addr_i[15:0];
    assign tx_full = tx_cnt == FULL;
    assign rx_full = rx_cnt == FULL;
    assign rx_ne   = rx_cnt != '0;

    assign tx_pop  = (tx_cnt != '0) && bus.io_tx_ready_i;
    assign tx_push = io_hit && bus.mem_wr_i && (io_off == 16'h0000);
    // A full FIFO still takes the byte when the host drains one this cycle.
    assign tx_acc  = tx_push && (!tx_full || tx_pop);
    assign ovf_clr = io_hit && bus.mem_wr_i && (io_off == 16'h0004);

    assign rx_push = bus.io_rx_valid_i && !rx_full;
    assign rx_pop  = io_hit && !bus.mem_wr_i && (io_off == 16'h0000) && rx_ne;

    assign bus.io_tx_data_o  = tx_mem[tx_rp];
    assign bus.io_tx_valid_o = tx_cnt != '0;
    assign bus.io_rx_ready_o = !rx_full;

    assign unused = ^bus.mem_addr_i[31:18];

    always_comb begin
        io_rd = 8'h00;
        if (io_off == 16'h0000 && rx_ne) begin
            io_rd = rx_mem[rx_rp];
        end else if (io_off == 16'h0004) begin
            io_rd = {5'b0, ovf, tx_full, rx_ne};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            ovf    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tx_mem[i] <= 8'h00;
            end
        end else begin
            if (tx_acc) begin
                tx_mem[tx_wp] <= bus.mem_data_i;
                tx_wp         <= tx_wp + PW'(1);
            end
            if (tx_pop) begin
                tx_rp <= tx_rp + PW'(1);
            end
            tx_cnt <= tx_cnt + CW'(tx_acc) - CW'(tx_pop);
            if (tx_push && !tx_acc) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                rx_mem[i] <= 8'h00;
            end
        end else begin
            if (rx_push) begin
                rx_mem[rx_wp] <= bus.io_rx_data_i;
                rx_wp         <= rx_wp + PW'(1);
            end
            if (rx_pop) begin
                rx_rp <= rx_rp + PW'(1);
            end
            rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
        end
    end
`else
    assign io_hit            = 1'b0;
    assign io_rd             = 8'h00;
    assign bus.io_tx_data_o  = 8'h00;
    assign bus.io_tx_valid_o = 1'b0;
    assign bus.io_rx_ready_o = 1'b0;

    assign unused = ^{bus.mem_addr_i[31:ADDR_BITS], bus.io_tx_ready_i,
                      bus.io_rx_data_i, bus.io_rx_valid_i};
`endif
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and random traffic checked against a queue model.
// I/O window scenarios are exercised when MEM_RESP_IO_EN is defined.
`timescale 1ns/1ps
module tb_mem_responder;
    localparam int D = 4;
    localparam logic [31:0] AMASK = 32'h0001_FFFF;
`ifdef MEM_RESP_IO_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    mem_responder_if bus ();

    mem_responder #(
        .ADDR_BITS (17),
        .FIFO_DEPTH(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] ram_m [int];
    logic [7:0] txq [$];
    logic [7:0] rxq [$];
    bit         ovf_m;
    logic [7:0] exp_rd;
    logic       txr;
    logic       rxv;
    logic [7:0] rxd;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".rd"}, bus.mem_data_o, exp_rd);
        chk({tag, ".txv"}, {7'b0, bus.io_tx_valid_o}, {7'b0, txq.size() != 0});
        if (txq.size() != 0) begin
            chk({tag, ".txd"}, bus.io_tx_data_o, txq[0]);
        end
`ifndef MEM_RESP_IO_EN
        chk({tag, ".txd0"}, bus.io_tx_data_o, 8'h00);
`endif
        chk({tag, ".rxr"}, {7'b0, bus.io_rx_ready_o},
            {7'b0, IO_EN && (rxq.size() < D)});
    endtask

    // One controller cycle: update the model from pre-edge state, then check.
    task automatic step(input string tag, input logic [31:0] a,
                        input logic w, input logic [7:0] d);
        bit io;
        bit pop_tx;
        bit push_rx;
        bit push_tx;
        bus.mem_addr_i    = a;
        bus.mem_data_i    = d;
        bus.mem_wr_i      = w;
        bus.io_tx_ready_i = txr;
        bus.io_rx_valid_i = rxv;
        bus.io_rx_data_i  = rxd;
        io      = IO_EN && (a[17:16] == 2'b11);
        pop_tx  = (txq.size() != 0) && txr;
        push_rx = rxv && (rxq.size() < D);
        push_tx = 1'b0;
        if (io) begin
            if (w) begin
                if (a[15:0] == 16'h0000) begin
                    if (txq.size() < D || pop_tx) push_tx = 1'b1;
                    else ovf_m = 1'b1;
                end else if (a[15:0] == 16'h0004) begin
                    ovf_m = 1'b0;
                end
            end else begin
                if (a[15:0] == 16'h0000) begin
                    if (rxq.size() != 0) exp_rd = rxq.pop_front();
                    else exp_rd = 8'h00;
                end else if (a[15:0] == 16'h0004) begin
                    exp_rd = {5'b0, ovf_m, txq.size() == D, rxq.size() != 0};
                end else begin
                    exp_rd = 8'h00;
                end
            end
        end else if (w) begin
            ram_m[int'(a & AMASK)] = d;
        end else begin
            exp_rd = ram_m[int'(a & AMASK)];
        end
        if (pop_tx) void'(txq.pop_front());
        if (push_tx) txq.push_back(d);
        if (push_rx) rxq.push_back(rxd);
        @(posedge clk);
        #1;
        check_outs(tag);
    endtask

    logic [31:0] rnd_addr [14];

    initial begin
        bus.mem_addr_i    = '0;
        bus.mem_data_i    = '0;
        bus.mem_wr_i      = 1'b0;
        bus.io_tx_ready_i = 1'b0;
        bus.io_rx_valid_i = 1'b0;
        bus.io_rx_data_i  = '0;
        txr    = 1'b0;
        rxv    = 1'b0;
        rxd    = 8'h00;
        ovf_m  = 1'b0;
        exp_rd = 8'h00;
        #1;
        check_outs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        step("wr_a5", 32'h0000_0010, 1'b1, 8'hA5);
        step("rd_a5", 32'h0000_0010, 1'b0, 8'h00);
        chk("rd_a5_const", bus.mem_data_o, 8'hA5);

        for (int i = 0; i < 4; i++)
            step("pre_100", 32'h100 + i, 1'b1, 8'h11 * (i + 1));
        for (int i = 0; i < 4; i++) begin
            step("b2b_rd", 32'h100 + i, 1'b0, 8'h00);
            chk("b2b_const", bus.mem_data_o, 8'h11 * (i + 1));
        end

        for (int i = 0; i < 8; i++)
            step("pre_200", 32'h200 + i, 1'b1, 8'($urandom));
        for (int i = 0; i < 3; i++)
            step("pre_10000", 32'h1_0000 + 4 * i, 1'b1, 8'($urandom));

`ifdef MEM_RESP_IO_EN
        for (int i = 0; i < 5; i++)
            step("tx_fill", 32'h3_0000, 1'b1, 8'h41 + 8'(i));
        step("tx_stat", 32'h3_0004, 1'b0, 8'h00);
        chk("tx_stat_const", bus.mem_data_o, 8'h06);
        txr = 1'b1;
        for (int i = 0; i < 5; i++)
            step("tx_drain", 32'h0000_0010, 1'b0, 8'h00);
        chk("tx_empty", {7'b0, bus.io_tx_valid_o}, 8'h00);

        step("ovf_clr", 32'h3_0004, 1'b1, 8'hFF);
        step("stat_clr", 32'h3_0004, 1'b0, 8'h00);
        chk("stat_clr_const", bus.mem_data_o, 8'h00);
        rxv = 1'b1;
        rxd = 8'h5A;
        step("rx_push", 32'h0000_0010, 1'b0, 8'h00);
        rxv = 1'b0;
        step("rx_stat", 32'h3_0004, 1'b0, 8'h00);
        chk("rx_stat_const", bus.mem_data_o, 8'h01);
        step("rx_rd", 32'h3_0000, 1'b0, 8'h00);
        chk("rx_rd_const", bus.mem_data_o, 8'h5A);
        step("rx_rd_empty", 32'h3_0000, 1'b0, 8'h00);
        chk("rx_empty_const", bus.mem_data_o, 8'h00);
        step("io_other", 32'h3_0008, 1'b0, 8'h00);

        txr = 1'b0;
        for (int i = 0; i < 4; i++)
            step("full_fill", 32'h3_0000, 1'b1, 8'h90 + 8'(i));
        txr = 1'b1;
        step("full_pp", 32'h3_0000, 1'b1, 8'h99);
        txr = 1'b0;
        step("full_stat", 32'h3_0004, 1'b0, 8'h00);
        chk("full_stat_const", bus.mem_data_o, 8'h02);
        txr = 1'b1;
        for (int i = 0; i < 4; i++)
            step("full_drain", 32'h0000_0010, 1'b0, 8'h00);
`else
        step("alias_wr", 32'h3_0000, 1'b1, 8'h77);
        step("alias_rd", 32'h1_0000, 1'b0, 8'h00);
        chk("alias_const", bus.mem_data_o, 8'h77);
`endif

        for (int i = 0; i < 8; i++) rnd_addr[i] = 32'h200 + i;
        rnd_addr[8]  = 32'h1_0000;
        rnd_addr[9]  = 32'h1_0004;
        rnd_addr[10] = 32'h3_0000;
        rnd_addr[11] = 32'h3_0004;
        rnd_addr[12] = 32'h3_0008;
        rnd_addr[13] = 32'hFFFC_0203;
        for (int n = 0; n < 400; n++) begin
            txr = 1'($urandom);
            rxv = 1'($urandom);
            rxd = 8'($urandom);
            step("rand", rnd_addr[$urandom_range(13, 0)],
                 1'($urandom), 8'($urandom));
        end

        txr = 1'b1;
        rxv = 1'b0;
        for (int i = 0; i < 5; i++)
            step("pre_rst_drain", 32'h0000_0010, 1'b0, 8'h00);
        txr = 1'b0;
`ifdef MEM_RESP_IO_EN
        for (int i = 0; i < 3; i++)
            step("pre_rst_tx", 32'h3_0000, 1'b1, 8'hC0 + 8'(i));
`endif
        step("pre_rst_rd", 32'h0000_0010, 1'b0, 8'h00);

        bus.mem_addr_i = 32'h100;
        bus.mem_wr_i   = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        txq.delete();
        rxq.delete();
        ovf_m  = 1'b0;
        exp_rd = 8'h00;
        check_outs("rst_mid");
        @(posedge clk);
        #1;
        check_outs("rst_hold");
        rst = 1'b1;
        step("post_rst", 32'h101, 1'b0, 8'h00);
        chk("post_rst_const", bus.mem_data_o, 8'h22);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
